// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, inverse S-box table, lane byte indexing and FSM states.
package aes_pkg;
   localparam int AES_STATE_W = 128;
   localparam int AES_BYTES = 16;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
   // Byte handled by a lane at a given step; the MSB group goes first.
   function automatic int byte_idx(int step, int lane, int lanes);
      return AES_BYTES - 1 - step * lanes - lane;
   endfunction
endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// inv_sub_bytes_iter_if: valid/ready input and output streams of the inverse SubBytes stage.
interface inv_sub_bytes_iter_if;
   import aes_pkg::*;
   logic in_valid, in_ready, out_valid, out_ready;
   logic [AES_STATE_W-1:0] in_state, out_state;
   modport master (output in_valid, in_state, out_ready, input in_ready, out_valid, out_state);
   modport slave (input in_valid, in_state, out_ready, output in_ready, out_valid, out_state);
endinterface

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box lookup.
module aes_inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] byte_val,
   output logic [7:0] sub_val
);
   assign sub_val = INV_SBOX[byte_val];
endmodule

// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES inverse SubBytes, LANES bytes per cycle, registered output.
module inv_sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input logic clk,
   input logic rst_n,
   inv_sub_bytes_iter_if.slave bus
);
   localparam int STEPS = AES_BYTES / LANES;
   localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("LANES must be 1, 2, 4, 8 or 16");
   end
   fsm_t state, state_n;
   logic [CW-1:0] cnt;
   logic [AES_STATE_W-1:0] work, sub, out_q;
   logic [7:0] sb_in [LANES];
   logic [7:0] sb_out [LANES];
   logic capture, last;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign sb_in[i] = work[byte_idx(int'(cnt), i, LANES)*8 +: 8];
      aes_inv_sbox u_sbox (.byte_val(sb_in[i]), .sub_val(sb_out[i]));
   end
   always_comb begin
      sub = work;
      for (int i = 0; i < LANES; i++) sub[byte_idx(int'(cnt), i, LANES)*8 +: 8] = sb_out[i];
   end
   assign last = cnt == CW'(STEPS - 1);
   assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
   assign capture = bus.in_valid && bus.in_ready;
   assign bus.out_valid = state == DONE;
   assign bus.out_state = out_q;
   // A capture from DONE covers the back-to-back case.
   always_comb begin
      state_n = state;
      state_n = capture ? BUSY
              : state == BUSY ? (last ? DONE : BUSY)
              : (state == DONE && bus.out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         work <= '0;
         out_q <= '0;
      end else begin
         state <= state_n;
         if (capture) begin
            work <= bus.in_state;
            cnt <= '0;
         end else if (state == BUSY) begin
            work <= sub;
            cnt <= last ? cnt : cnt + 1'b1;
            if (last) out_q <= sub;
         end
      end
   end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter: scoreboard bench; expected bytes come from an S-box computed in GF(2^8).
module tb_inv_sub_bytes_iter;
   import aes_pkg::*;
   localparam int LANES = 4;
   localparam int STEPS = AES_BYTES / LANES;
   logic clk = 0;
   logic rst_n = 0;
   int passed = 0;
   int total = 0;
   logic [7:0] inv_tab [256];
   logic [127:0] exp_q [$];
   inv_sub_bytes_iter_if bus();
   inv_sub_bytes_iter #(.LANES(LANES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] fwd_sbox(logic [7:0] x);
      logic [7:0] y = 0;
      for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) y = 8'(c);
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] model(logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tab[s[i*8 +: 8]];
      return r;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] d, output bit ok);
      int n = 0;
      while (!bus.in_ready && n < 100) begin
         cycle();
         n++;
      end
      ok = bus.in_ready;
      bus.in_valid = 1;
      bus.in_state = d;
      exp_q.push_back(model(d));
      cycle();
      bus.in_valid = 0;
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         cycle();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      bus.in_valid = 0;
      bus.out_ready = 0;
      bus.in_state = '0;
      repeat (3) cycle();
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); else passed++;
      total++; if (bus.out_state !== '0) $display("FAIL reset_out_state: got %h exp 0", bus.out_state); else passed++;
      rst_n = 1;
      cycle();
      total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); else passed++;
   endtask

   task automatic test_latency();
      bit ok;
      int lat;
      logic [127:0] e;
      bus.out_ready = 1;
      send({16{8'h63}}, ok);
      total++; if (!ok) $display("FAIL lat_accept: got in_ready 0 exp 1"); else passed++;
      wait_out(lat);
      total++; if (lat != STEPS) $display("FAIL lat_cycles: got %0d exp %0d", lat, STEPS); else passed++;
      e = exp_q.size() ? exp_q.pop_front() : '1;
      total++; if (bus.out_state !== e) $display("FAIL lat_data: got %h exp %h", bus.out_state, e); else passed++;
      total++; if (bus.out_state !== '0) $display("FAIL lat_all63: got %h exp 0", bus.out_state); else passed++;
      cycle();
      total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_drop: got %b exp 0", bus.out_valid); else passed++;
   endtask

   task automatic test_sweep();
      bit ok;
      int lat;
      logic [127:0] d, e;
      bus.out_ready = 1;
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(k * 16 + 15 - i);
         send(d, ok);
         wait_out(lat);
         total++; if (lat != STEPS) $display("FAIL sweep_lat%0d: got %0d exp %0d", k, lat, STEPS); else passed++;
         e = exp_q.size() ? exp_q.pop_front() : '1;
         total++; if (bus.out_state !== e) $display("FAIL sweep_blk%0d: got %h exp %h", k, bus.out_state, e); else passed++;
         if (k == 0) begin
            total++;
            if (bus.out_state[127:104] !== 24'h52096a || bus.out_state[7:0] !== 8'hfb)
               $display("FAIL sweep_known: got %h..%h exp 52096a..fb", bus.out_state[127:104], bus.out_state[7:0]);
            else passed++;
         end
         cycle();
      end
   endtask

   task automatic test_stall();
      bit ok;
      int lat;
      logic [127:0] e, hold, d2;
      bus.out_ready = 0;
      send({$urandom, $urandom, $urandom, $urandom}, ok);
      wait_out(lat);
      total++; if (lat != STEPS) $display("FAIL stall_lat: got %0d exp %0d", lat, STEPS); else passed++;
      e = exp_q.size() ? exp_q.pop_front() : '1;
      total++; if (bus.out_state !== e) $display("FAIL stall_data: got %h exp %h", bus.out_state, e); else passed++;
      hold = bus.out_state;
      d2 = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid = 1;
      bus.in_state = d2;
      exp_q.push_back(model(d2));
      for (int c = 0; c < 10; c++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_state !== hold || bus.in_ready !== 1'b0)
            $display("FAIL stall_hold%0d: got v=%b r=%b %h exp v=1 r=0 %h", c, bus.out_valid, bus.in_ready, bus.out_state, hold);
         else passed++;
         cycle();
      end
      bus.out_ready = 1;
      cycle();
      bus.in_valid = 0;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL stall_release: got %b exp 0", bus.out_valid); else passed++;
      wait_out(lat);
      total++; if (lat != STEPS) $display("FAIL stall_lat2: got %0d exp %0d", lat, STEPS); else passed++;
      e = exp_q.size() ? exp_q.pop_front() : '1;
      total++; if (bus.out_state !== e) $display("FAIL stall_data2: got %h exp %h", bus.out_state, e); else passed++;
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [127:0] blk [8];
      logic [127:0] e;
      int sent = 0, got = 0, cyc = 0, last = 0;
      bit hs_in;
      for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = 1;
      bus.in_valid = 1;
      bus.in_state = blk[0];
      exp_q.push_back(model(blk[0]));
      sent = 1;
      while (got < 8 && cyc < 300) begin
         hs_in = bus.in_valid && bus.in_ready;
         if (bus.out_valid) begin
            e = exp_q.size() ? exp_q.pop_front() : '1;
            total++; if (bus.out_state !== e) $display("FAIL b2b_data%0d: got %h exp %h", got, bus.out_state, e); else passed++;
            // One DONE cycle separates consecutive BUSY phases.
            if (got > 0) begin
               total++; if (cyc - last != STEPS + 1) $display("FAIL b2b_gap%0d: got %0d exp %0d", got, cyc - last, STEPS + 1); else passed++;
            end
            last = cyc;
            got++;
         end
         cycle();
         cyc++;
         if (hs_in) begin
            if (sent < 8) begin
               bus.in_state = blk[sent];
               exp_q.push_back(model(blk[sent]));
               sent++;
            end else bus.in_valid = 0;
         end
      end
      bus.in_valid = 0;
      total++; if (got != 8) $display("FAIL b2b_count: got %0d exp 8", got); else passed++;
      total++; if (exp_q.size() != 0) $display("FAIL b2b_leftover: got %0d exp 0", exp_q.size()); else passed++;
      cycle();
   endtask

   task automatic test_reset_busy();
      bit ok;
      int lat;
      logic [127:0] e;
      bus.out_ready = 1;
      send({$urandom, $urandom, $urandom, $urandom}, ok);
      repeat (2) cycle();
      rst_n = 0;
      #1;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_busy_valid: got %b exp 0", bus.out_valid); else passed++;
      total++; if (bus.out_state !== '0) $display("FAIL rst_busy_state: got %h exp 0", bus.out_state); else passed++;
      exp_q.delete();
      cycle();
      rst_n = 1;
      cycle();
      total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL rst_busy_idle: got r=%b v=%b exp r=1 v=0", bus.in_ready, bus.out_valid); else passed++;
      send({$urandom, $urandom, $urandom, $urandom}, ok);
      wait_out(lat);
      total++; if (lat != STEPS) $display("FAIL rst_busy_lat: got %0d exp %0d", lat, STEPS); else passed++;
      e = exp_q.size() ? exp_q.pop_front() : '1;
      total++; if (bus.out_state !== e) $display("FAIL rst_busy_data: got %h exp %h", bus.out_state, e); else passed++;
      cycle();
   endtask

   initial begin
      for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
      test_reset();
      test_latency();
      test_sweep();
      test_stall();
      test_back_to_back();
      test_reset_busy();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
